// File: rtl/rwc_vote_ctrl.sv
// Challenge sequencer and majority voter for the read-write collision generator.
// Runs REPS enable/available handshakes per challenge and publishes voted bits plus a stability mask.
module rwc_vote_ctrl #(
  parameter int unsigned REPS    = 15,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = $clog2(REPS + 1)
) (
  input  logic        clk,
  input  logic        w_resetn,
  input  logic        start,
  input  logic [9:0]  ch_addr,
  input  logic [31:0] ch_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rsp_bits,
  output logic [31:0] rsp_stable,
  output logic        timeout_err,
  output logic        gen_enable,
  output logic [9:0]  cha_addr,
  output logic [31:0] cha_data,
  input  logic        available,
  input  logic [31:0] rsp_write,
  input  logic [31:0] rsp_clean
);

  localparam int unsigned   WW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] REPS_C    = CW'(REPS);
  localparam logic [CW-1:0] HALF_C    = CW'(REPS / 2);
  localparam logic [7:0]    LAST_REP  = 8'(REPS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    ACCUM,
    FINISH
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt [32];
  logic [7:0]    rep_cnt;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   raw;

  logic accept;
  logic fire;
  logic wait_clr;
  logic tmo;

  // XOR with the post-clear read cancels stuck or uncleared cells
  assign raw = rsp_write ^ rsp_clean;

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    fire     = 1'b0;
    wait_clr = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        // busy is still high during the done cycle, so a start there is dropped
        if (start && !busy) begin
          accept  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (available) begin
          fire     = 1'b1;
          wait_clr = 1'b1;
          state_d  = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!available) begin
          wait_clr = 1'b1;
          state_d  = WAIT_HI;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo     = 1'b1;
          state_d = FINISH;
        end
      end
      WAIT_HI: begin
        if (available) begin
          state_d = ACCUM;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo     = 1'b1;
          state_d = FINISH;
        end
      end
      ACCUM: begin
        state_d = (rep_cnt == LAST_REP) ? FINISH : LAUNCH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      gen_enable  <= 1'b0;
      timeout_err <= 1'b0;
      rsp_bits    <= '0;
      rsp_stable  <= '0;
      cha_addr    <= '0;
      cha_data    <= '0;
      rep_cnt     <= '0;
      wait_cnt    <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state      <= state_d;
      gen_enable <= fire;
      done       <= (state == FINISH);
      busy       <= accept | (busy & ~done);

      if (accept) begin
        cha_addr    <= ch_addr;
        cha_data    <= ch_data;
        rep_cnt     <= '0;
        timeout_err <= 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
          cnt[i] <= '0;
        end
      end

      if (wait_clr) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_LO) || (state == WAIT_HI)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (tmo) begin
        timeout_err <= 1'b1;
      end

      if (state == ACCUM) begin
        rep_cnt <= rep_cnt + 8'd1;
        for (int unsigned i = 0; i < 32; i++) begin
          if (raw[i] && (cnt[i] != REPS_C)) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end

      if (state == FINISH) begin
        for (int unsigned i = 0; i < 32; i++) begin
          if (timeout_err) begin
            rsp_bits[i]   <= 1'b0;
            rsp_stable[i] <= 1'b0;
          end else begin
            rsp_bits[i]   <= (cnt[i] > HALF_C);
            rsp_stable[i] <= (cnt[i] == '0) || (cnt[i] == REPS_C);
          end
        end
      end
    end
  end

endmodule
